// File: rtl/fsm_mealy_seqdet.sv
// Mealy serial-pattern detector with a saturating match counter.
// History shift register plus fill counter; optional overlap and registered bo.
module fsm_mealy_seqdet #(
  parameter int unsigned    N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter int unsigned    OVERLAP = 1,
  parameter int unsigned    REG_OUT = 0,
  parameter int unsigned    CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             bi,
  input  logic             clr_cnt,
  output logic             bo,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam int unsigned        FILL_W   = $clog2(N);
  localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(N - 1);

  logic [N-2:0]     hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     win;
  logic             hit_c;

  // Match detection and next-state for history, fill and counter
  always_comb begin
    win    = {hist_q, bi};
    hit_c  = en && (fill_q == FILL_MAX) && (win == PATTERN);
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;

    if (en) begin
      if (hit_c && (OVERLAP == 0)) begin
        // Non-overlap: the matching bits are consumed, search restarts clean
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = win[N-2:0];
        if (fill_q != FILL_MAX) begin
          fill_d = fill_q + FILL_W'(1);
        end
      end
    end

    // Clear wins over a simultaneous hit; counter saturates at all ones
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (hit_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_bo
      logic bo_q, bo_d;

      // Registered match flag, one cycle after the completing bit
      always_comb begin
        bo_d = hit_c;
      end

      // Match flag register
      always_ff @(posedge clk) begin
        if (reset) begin
          bo_q <= 1'b0;
        end else begin
          bo_q <= bo_d;
        end
      end

      assign bo = bo_q;
    end else begin : g_comb_bo
      // Zero-latency Mealy flag, held low during reset
      assign bo = hit_c & ~reset;
    end
  endgenerate

  assign match_cnt = cnt_q;
  assign armed     = (fill_q == FILL_MAX);

endmodule
